// File: rtl/vga_timing_gen_if.sv
// vga_timing_gen_if: bus between the VGA timing generator and its consumers
// master (generator): takes en, drives pixel strobe, sync/blank, coordinates, ticks, board addressing, frame_cnt
// slave (consumer): drives en, observes everything else
interface vga_timing_gen_if;
  logic en;
  logic pix_ce;
  logic hs;
  logic vs;
  logic blank_n;
  logic de;
  logic [10:0] x;
  logic [9:0] y;
  logic line_start;
  logic frame_start;
  logic in_board;
  logic [3:0] cell_col;
  logic [4:0] cell_row;
  logic grid_line;
  logic [15:0] frame_cnt;
  modport master(
    input en,
    output pix_ce, hs, vs, blank_n, de, x, y, line_start, frame_start,
    output in_board, cell_col, cell_row, grid_line, frame_cnt
  );
  modport slave(
    output en,
    input pix_ce, hs, vs, blank_n, de, x, y, line_start, frame_start,
    input in_board, cell_col, cell_row, grid_line, frame_cnt
  );
endinterface

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: parametrised VGA raster timing with pixel strobe, sync/blank, coordinates, ticks and tetris board addressing
// clk: system clock; rst: asynchronous active-high reset
// bus (vga_timing_gen_if.master): en in; pix_ce, hs, vs, blank_n, de, x, y, line_start, frame_start,
//   in_board, cell_col, cell_row, grid_line, frame_cnt out (all registered)
// VGA_FRAME_CNT_EN: when defined frame_cnt counts frame_starts, otherwise it is tied to 0
module vga_timing_gen #(
  parameter int PIX_DIV = 2,
  parameter int H_ACT = 640,
  parameter int H_FRONT = 16,
  parameter int H_SYNC = 96,
  parameter int H_BACK = 48,
  parameter int V_ACT = 480,
  parameter int V_FRONT = 10,
  parameter int V_SYNC = 2,
  parameter int V_BACK = 33,
  parameter int HS_POL = 0,
  parameter int VS_POL = 0,
  parameter int BOARD_X0 = 240,
  parameter int BOARD_Y0 = 80,
  parameter int BOARD_COLS = 10,
  parameter int BOARD_ROWS = 20,
  parameter int CELL_SHIFT = 4
) (
  input logic clk,
  input logic rst,
  vga_timing_gen_if.master bus
);
  localparam int H_TOTAL = H_ACT + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_ACT + V_FRONT + V_SYNC + V_BACK;
  localparam int DW = PIX_DIV > 1 ? $clog2(PIX_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(PIX_DIV - 1);
  localparam logic [10:0] H_LAST = 11'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);
  // compare constants carry one spare bit so a sync pulse ending exactly at the total cannot wrap
  localparam logic [11:0] H_A = 12'(H_ACT);
  localparam logic [11:0] HS_B = 12'(H_ACT + H_FRONT);
  localparam logic [11:0] HS_E = 12'(H_ACT + H_FRONT + H_SYNC);
  localparam logic [10:0] V_A = 11'(V_ACT);
  localparam logic [10:0] VS_B = 11'(V_ACT + V_FRONT);
  localparam logic [10:0] VS_E = 11'(V_ACT + V_FRONT + V_SYNC);
  localparam logic [11:0] BX0 = 12'(BOARD_X0);
  localparam logic [11:0] BX1 = 12'(BOARD_X0 + (BOARD_COLS << CELL_SHIFT));
  localparam logic [10:0] BY0 = 11'(BOARD_Y0);
  localparam logic [10:0] BY1 = 11'(BOARD_Y0 + (BOARD_ROWS << CELL_SHIFT));
  localparam logic [10:0] CMASK = 11'((1 << CELL_SHIFT) - 1);
  localparam logic HS_ON = HS_POL != 0;
  localparam logic VS_ON = VS_POL != 0;
  logic [DW-1:0] div;
  logic [10:0] hcnt, nh, n_x, ox, oy;
  logic [9:0] vcnt, nv, n_y;
  logic step, n_hs, n_vs, n_de, n_inb, n_grid;
  logic [3:0] n_col;
  logic [4:0] n_row;
  // outputs are computed from the post-step position so they land on the same edge as the counters
  always_comb begin
    step = bus.en && div == DIV_LAST;
    nh = hcnt == H_LAST ? '0 : hcnt + 11'd1;
    nv = hcnt != H_LAST ? vcnt : vcnt == V_LAST ? '0 : vcnt + 10'd1;
    n_hs = {1'b0, nh} >= HS_B && {1'b0, nh} < HS_E ? HS_ON : ~HS_ON;
    n_vs = {1'b0, nv} >= VS_B && {1'b0, nv} < VS_E ? VS_ON : ~VS_ON;
    n_de = {1'b0, nh} < H_A && {1'b0, nv} < V_A;
    n_x = n_de ? nh : '0;
    n_y = n_de ? nv : '0;
    ox = n_x - BX0[10:0];
    oy = {1'b0, n_y} - BY0;
    n_inb = n_de && {1'b0, n_x} >= BX0 && {1'b0, n_x} < BX1 && {1'b0, n_y} >= BY0 && {1'b0, n_y} < BY1;
    n_col = n_inb ? 4'(ox >> CELL_SHIFT) : '0;
    n_row = n_inb ? 5'(oy >> CELL_SHIFT) : '0;
    n_grid = n_inb && ((ox & CMASK) == '0 || (oy & CMASK) == '0);
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div <= '0;
      hcnt <= H_LAST;
      vcnt <= V_LAST;
      bus.pix_ce <= 1'b0;
      bus.line_start <= 1'b0;
      bus.frame_start <= 1'b0;
      bus.hs <= ~HS_ON;
      bus.vs <= ~VS_ON;
      bus.de <= 1'b0;
      bus.blank_n <= 1'b0;
      bus.x <= '0;
      bus.y <= '0;
      bus.in_board <= 1'b0;
      bus.cell_col <= '0;
      bus.cell_row <= '0;
      bus.grid_line <= 1'b0;
    end else begin
      bus.pix_ce <= step;
      bus.line_start <= step && nh == '0;
      bus.frame_start <= step && nh == '0 && nv == '0;
      if (bus.en) div <= div == DIV_LAST ? '0 : div + DW'(1);
      if (step) begin
        hcnt <= nh;
        vcnt <= nv;
        bus.hs <= n_hs;
        bus.vs <= n_vs;
        bus.de <= n_de;
        bus.blank_n <= n_de;
        bus.x <= n_x;
        bus.y <= n_y;
        bus.in_board <= n_inb;
        bus.cell_col <= n_col;
        bus.cell_row <= n_row;
        bus.grid_line <= n_grid;
      end
    end
  end
`ifdef VGA_FRAME_CNT_EN
  logic [15:0] fc;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) fc <= '0;
    else if (step && nh == '0 && nv == '0) fc <= fc + 16'd1;
  end
  assign bus.frame_cnt = fc;
`else
  assign bus.frame_cnt = '0;
`endif
endmodule
